// File: rtl/imem_program_writer.sv
// imem_program_writer: encodes instruction field tuples into 32-bit ISA words
// and writes them to consecutive instruction-memory addresses.
//
// Handshake: a tuple transfers on a rising clock edge where in_valid and in_ready
// are both 1. in_ready is a function of the FSM state only. While in_valid is 0,
// the producer's fields are ignored. Every accepted tuple is consumed exactly once,
// whether or not its opcode is legal.
module imem_program_writer #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_aluop,
  input  logic [16:0]       in_imm,
  input  logic [26:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc;
  logic              legal;

  // Encode the presented tuple; fields a format does not use are left at zero.
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (in_opcode)
      5'b00000:
        enc = {in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
      5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110:
        enc = {in_opcode, in_rd, in_rs, in_imm};
      5'b00001, 5'b00011, 5'b10101, 5'b10110:
        enc = {in_opcode, in_target};
      5'b00100:
        enc = {in_opcode, in_rd, 22'd0};
      default:
        legal = 1'b0;
    endcase
  end

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Session FSM plus the registered write port and sticky session status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      count       <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_data   <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_LOAD;
            ptr         <= start_addr;
            count       <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (legal) begin
              imem_we   <= 1'b1;
              imem_addr <= ptr;
              imem_data <= enc;
              count     <= count + 1'b1;
              // The top address is the last writable word; the pointer never wraps.
              if (ptr != PTR_MAX) begin
                ptr <= ptr + 1'b1;
              end
              if (in_last) begin
                state <= S_DONE;
              end else if (ptr == PTR_MAX) begin
                state <= S_FULL;
              end
            end else begin
              err_illegal <= 1'b1;
              if (in_last) begin
                state <= S_DONE;
              end
            end
          end
        end
        S_FULL: begin
          err_full <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_writer.sv
// Self-checking bench for imem_program_writer: reset values, an encoding table,
// hand-written session corner cases, and randomized sessions against a reference model.
module tb_imem_program_writer;

  localparam int AW = 12;

  typedef struct {
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic [16:0] imm;
    logic [26:0] target;
  } tuple_t;

  typedef struct {
    tuple_t      t;
    bit          legal;
    logic [31:0] data;
  } vec_t;

  // Clock/reset and DUT signals
  logic          clock;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop;
  logic [16:0]   in_imm;
  logic [26:0]   in_target;
  logic          in_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          busy, done, err_illegal, err_full;
  logic [AW:0]   count;
  logic [1:0]    dbg_state;

  // Small instance (2-bit address space) for the exhaustion case
  logic          s_start;
  logic [1:0]    s_start_addr;
  logic          s_in_valid, s_in_ready, s_in_last;
  logic          s_imem_we;
  logic [1:0]    s_imem_addr;
  logic [31:0]   s_imem_data;
  logic          s_busy, s_done, s_err_illegal, s_err_full;
  logic [2:0]    s_count;
  logic [1:0]    s_dbg_state;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected writes, each entry {addr, data}
  logic [AW+31:0] exp_q[$];

  // Reference model session state
  logic [AW-1:0] m_ptr;
  int            m_count;
  bit            m_ill;
  bit            m_full;

  vec_t vecs[$];

  imem_program_writer #(.ADDR_W(AW)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_aluop(in_aluop),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_data(imem_data), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_full(err_full), .count(count), .dbg_state(dbg_state)
  );

  imem_program_writer #(.ADDR_W(2)) u_small (
    .clock(clock), .reset_n(reset_n), .start(s_start), .start_addr(s_start_addr),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_aluop(in_aluop),
    .in_imm(in_imm), .in_target(in_target), .in_last(s_in_last), .imem_we(s_imem_we),
    .imem_addr(s_imem_addr), .imem_data(s_imem_data), .busy(s_busy), .done(s_done),
    .err_illegal(s_err_illegal), .err_full(s_err_full), .count(s_count),
    .dbg_state(s_dbg_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge and reconcile the write port with the scoreboard.
  task automatic step();
    logic [AW+31:0] e;
    @(posedge clock);
    #1;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_write: got addr=%0h data=%0h, required no write",
                 imem_addr, imem_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_write", {imem_addr, imem_data}, e);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL sb_missing_write: got no write, required addr=%0h data=%0h",
               e[AW+31:32], e[31:0]);
    end
  endtask

  function automatic tuple_t mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] al,
                                input logic [16:0] imm, input logic [26:0] tgt);
    tuple_t t;
    t.opcode = op; t.rd = rd; t.rs = rs; t.rt = rt;
    t.shamt = sh; t.aluop = al; t.imm = imm; t.target = tgt;
    return t;
  endfunction

  task automatic add_vec(input tuple_t t, input bit legal, input logic [31:0] d);
    vec_t v;
    v.t = t; v.legal = legal; v.data = d;
    vecs.push_back(v);
  endtask

  // Reference encoder: each field weighted by its bit position, by format.
  function automatic logic [31:0] ref_enc(input tuple_t t, output bit legal);
    longint w;
    legal = 1'b1;
    w = longint'(t.opcode) * 64'd134217728;
    if (t.opcode == 5'd0)
      w += longint'(t.rd) * 64'd4194304 + longint'(t.rs) * 64'd131072 +
           longint'(t.rt) * 64'd4096 + longint'(t.shamt) * 64'd128 + longint'(t.aluop) * 64'd4;
    else if (t.opcode inside {5'd5, 5'd7, 5'd8, 5'd2, 5'd6})
      w += longint'(t.rd) * 64'd4194304 + longint'(t.rs) * 64'd131072 + longint'(t.imm);
    else if (t.opcode inside {5'd1, 5'd3, 5'd21, 5'd22})
      w += longint'(t.target);
    else if (t.opcode == 5'd4)
      w += longint'(t.rd) * 64'd4194304;
    else begin
      legal = 1'b0;
      w = 0;
    end
    return w[31:0];
  endfunction

  // Model one accepted tuple; reports whether the session ends with it.
  task automatic model_accept(input tuple_t t, input bit last, output bit ended);
    logic [31:0] d;
    bit lg;
    d = ref_enc(t, lg);
    ended = 1'b0;
    if (lg) begin
      exp_q.push_back({m_ptr, d});
      m_count++;
      if (last) ended = 1'b1;
      else if (m_ptr == {AW{1'b1}}) begin
        ended = 1'b1;
        m_full = 1'b1;
      end else m_ptr++;
    end else begin
      m_ill = 1'b1;
      if (last) ended = 1'b1;
    end
  endtask

  function automatic tuple_t rand_tuple();
    tuple_t t;
    logic [4:0] ops [0:10] = '{5'd0, 5'd5, 5'd7, 5'd8, 5'd2, 5'd6, 5'd1, 5'd3, 5'd21, 5'd22, 5'd4};
    if ($urandom_range(0, 4) != 0) t.opcode = ops[$urandom_range(0, 10)];
    else t.opcode = 5'($urandom_range(0, 31));
    t.rd = 5'($urandom); t.rs = 5'($urandom); t.rt = 5'($urandom);
    t.shamt = 5'($urandom); t.aluop = 5'($urandom);
    t.imm = 17'($urandom); t.target = 27'($urandom);
    return t;
  endfunction

  task automatic drive_fields(input tuple_t t);
    in_opcode = t.opcode; in_rd = t.rd; in_rs = t.rs; in_rt = t.rt;
    in_shamt = t.shamt; in_aluop = t.aluop; in_imm = t.imm; in_target = t.target;
  endtask

  // Present one tuple for exactly one accepting edge.
  task automatic send(input tuple_t t, input bit last);
    drive_fields(t);
    in_last  = last;
    in_valid = 1'b1;
    chk("in_ready_load", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] a);
    start = 1'b1;
    start_addr = a;
    step();
    start = 1'b0;
    m_ptr = a; m_count = 0; m_ill = 1'b0; m_full = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_count", count, 0);
  endtask

  task automatic wait_done(input int max_cycles);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("done_seen", found, 1'b1);
    step();
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    tuple_t t;
    bit ended;
    logic [AW-1:0] taddr;
    int len;

    reset_n = 1'b0;
    start = 1'b0; start_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    s_start = 1'b0; s_start_addr = '0; s_in_valid = 1'b0; s_in_last = 1'b0;
    drive_fields(mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_imem_we", imem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_errs", {err_illegal, err_full}, 2'b00);
    chk("rst_addr_data", {imem_addr, imem_data}, 0);
    chk("rst_count", count, 0);
    chk("rst_small_count", s_count, 0);
    reset_n = 1'b1;
    step();

    // Single addi session: write one cycle after accept, done one cycle after the write
    do_start(12'h010);
    t = mk(5'b00101, 1, 0, 0, 0, 0, 17'd5, 27'd0);
    model_accept(t, 1'b1, ended);
    send(t, 1'b1);
    chk("t1_we", imem_we, 1'b1);
    chk("t1_addr", imem_addr, 12'h010);
    chk("t1_data", imem_data, 32'h28400005);
    chk("t1_done_early", done, 1'b0);
    step();
    chk("t1_done", done, 1'b1);
    chk("t1_busy", busy, 1'b0);
    chk("t1_count", count, 1);
    step();
    chk("t1_done_drop", done, 1'b0);

    // Encoding table, streamed back-to-back in one session
    add_vec(mk(5'b00101, 1, 0, 9, 3, 2, 17'd5, 27'h5a5a5a), 1'b1, 32'h28400005);
    add_vec(mk(5'b00000, 1, 2, 3, 0, 0, 17'h1ffff, 27'h7ffffff), 1'b1, 32'h00443000);
    add_vec(mk(5'b00011, 7, 7, 7, 7, 7, 17'h1234, 27'h64), 1'b1, 32'h18000064);
    add_vec(mk(5'b00100, 31, 4, 4, 4, 4, 17'h1, 27'h1), 1'b1, 32'h27C00000);
    add_vec(mk(5'b00000, 5, 6, 7, 4, 3, 17'd0, 27'd0), 1'b1, 32'h014C720C);
    add_vec(mk(5'b00111, 2, 3, 31, 31, 31, 17'h1ffff, 27'd0), 1'b1, 32'h3887FFFF);
    add_vec(mk(5'b00001, 31, 31, 31, 31, 31, 17'h1ffff, 27'h7ffffff), 1'b1, 32'h0FFFFFFF);
    add_vec(mk(5'b00100, 3, 5, 0, 0, 0, 17'd0, 27'd0), 1'b1, 32'h20C00000);
    add_vec(mk(5'b10110, 0, 0, 0, 0, 0, 17'd0, 27'h1234567), 1'b1, 32'hB1234567);
    add_vec(mk(5'b01111, 1, 2, 3, 4, 5, 17'd6, 27'd7), 1'b0, 32'h0);
    add_vec(mk(5'b00110, 31, 31, 0, 0, 0, 17'h10000, 27'd0), 1'b1, 32'h37FF0000);
    add_vec(mk(5'b10101, 0, 0, 0, 0, 0, 17'd0, 27'h1), 1'b1, 32'hA8000001);
    add_vec(mk(5'b01000, 4, 1, 0, 0, 0, 17'h10, 27'd0), 1'b1, 32'h41020010);
    add_vec(mk(5'b11111, 9, 9, 9, 9, 9, 17'd9, 27'd9), 1'b0, 32'h0);
    add_vec(mk(5'b00010, 0, 0, 0, 0, 0, 17'habc, 27'd0), 1'b1, 32'h10000ABC);

    do_start(12'h010);
    taddr = 12'h010;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].legal) begin
        exp_q.push_back({taddr, vecs[i].data});
        taddr++;
      end
      send(vecs[i].t, i == vecs.size() - 1);
      chk("tbl_we", imem_we, vecs[i].legal);
      if (vecs[i].legal) chk("tbl_data", imem_data, vecs[i].data);
    end
    wait_done(4);
    chk("tbl_count", count, 13);
    chk("tbl_err_illegal", err_illegal, 1'b1);
    chk("tbl_err_full", err_full, 1'b0);

    // Address-space exhaustion on the 2-bit instance
    s_start = 1'b1; s_start_addr = 2'd3;
    step();
    s_start = 1'b0;
    chk("full_ready", s_in_ready, 1'b1);
    drive_fields(mk(5'b00101, 1, 0, 0, 0, 0, 17'd5, 27'd0));
    s_in_valid = 1'b1;
    step();
    chk("full_we", s_imem_we, 1'b1);
    chk("full_addr", s_imem_addr, 2'd3);
    chk("full_data", s_imem_data, 32'h28400005);
    chk("full_ready_off", s_in_ready, 1'b0);
    drive_fields(mk(5'b00011, 0, 0, 0, 0, 0, 17'd0, 27'h64));
    step();
    chk("full_no_2nd_we", s_imem_we, 1'b0);
    chk("full_err", s_err_full, 1'b1);
    step();
    chk("full_done", s_done, 1'b1);
    chk("full_busy", s_busy, 1'b0);
    s_in_valid = 1'b0;
    step();
    chk("full_count", s_count, 1);
    chk("full_err_hold", s_err_full, 1'b1);

    // start during LOAD is ignored
    do_start(12'h100);
    t = mk(5'b00000, 1, 2, 3, 0, 0, 17'd0, 27'd0);
    model_accept(t, 1'b0, ended);
    send(t, 1'b0);
    t = mk(5'b01111, 0, 0, 0, 0, 0, 17'd0, 27'd0);
    model_accept(t, 1'b0, ended);
    send(t, 1'b0);
    chk("ign_count_pre", count, 1);
    start = 1'b1; start_addr = 12'h200;
    step();
    start = 1'b0;
    chk("ign_count", count, 1);
    chk("ign_err_illegal", err_illegal, 1'b1);
    chk("ign_state", dbg_state, 2'd1);
    t = mk(5'b00100, 31, 0, 0, 0, 0, 17'd0, 27'd0);
    model_accept(t, 1'b1, ended);
    send(t, 1'b1);
    chk("ign_addr", imem_addr, 12'h101);
    wait_done(4);
    chk("ign_final_count", count, 2);

    // Reset in the middle of a session with in_valid held
    do_start(12'h020);
    t = mk(5'b00000, 4, 5, 6, 1, 2, 17'd0, 27'd0);
    model_accept(t, 1'b0, ended);
    drive_fields(t);
    in_valid = 1'b1;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", imem_we, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ready", in_ready, 1'b0);
    step();
    chk("mid_rst_we_hold", imem_we, 1'b0);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
    chk("mid_rst_idle", busy, 1'b0);

    // Randomized sessions against the reference model
    for (int s = 0; s < 10; s++) begin
      if ($urandom_range(0, 2) == 0) do_start(AW'($urandom_range(4086, 4095)));
      else do_start(AW'($urandom_range(0, 4000)));
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) step();
        t = rand_tuple();
        model_accept(t, i == len - 1, ended);
        send(t, i == len - 1);
        if (ended) break;
      end
      wait_done(6);
      chk("rnd_count", count, m_count);
      chk("rnd_err_illegal", err_illegal, m_ill);
      chk("rnd_err_full", err_full, m_full);
    end

    step();
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
